// File: rtl/skid_buffer.sv
// Two-entry elastic register slice. Latency: 1 cycle, one transfer per cycle.
// Backpressure: in_ready comes only from the state flop; a second entry skids while out_ready is low.
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_valid) begin
          load_main_in = 1'b1;
          state_nxt    = FULL;
        end
      end
      FULL: begin
        if (in_valid && out_ready) begin
          load_main_in = 1'b1;
        end else if (in_valid) begin
          load_skid = 1'b1;
          state_nxt = SKID;
        end else if (out_ready) begin
          state_nxt = EMPTY;
        end
      end
      SKID: begin
        if (out_ready) begin
          load_main_skid = 1'b1;
          state_nxt      = FULL;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush drops everything, including any entry offered this cycle.
    if (flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != SKID);
  assign out_data  = main_q;
  assign count     = {state == SKID, state == FULL};

endmodule

// File: doc/skid_buffer.md
# skid_buffer

- Elastic register slice between a producer stage and a consumer stage: valid/ready handshake on both sides, two entries of storage, full throughput.
- Forms the handshake end of the pipeline registers; a plain enable register is controlled from outside, while this block decides for itself when to accept and when to hold.
- Inserted on long or timing-critical paths to cut both the forward path (data/valid) and the backward path (ready) with flops.
- Sustains one transfer per cycle with 1-cycle latency.

## Interface
Parameters:
- WIDTH, 8, data width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all buffered entries.
- in_valid  input  1  producer has data on in_data.
- in_ready  output  1  block can accept; transfer when in_valid & in_ready at posedge.
- in_data  input  WIDTH  producer data.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  consumer accepts; transfer when out_valid & out_ready at posedge.
- out_data  output  WIDTH  head entry.
- count  output  2  occupancy, 0..2.

## Operation
- Storage: main register (drives out_data) and skid register.
- State register: EMPTY (count 0), FULL (count 1), SKID (count 2). Encoding is free.
- out_valid = (state != EMPTY).
- in_ready = (state != SKID). It is decoded from the state flop only, with no combinational path from out_ready or in_valid.
- count is decoded from state.
- EMPTY:
  - in_valid: main <= in_data, go to FULL.
  - Otherwise stay in EMPTY.
- FULL:
  - in_valid & out_ready: main <= in_data, stay in FULL (pass-through, one transfer per side).
  - in_valid & !out_ready: skid <= in_data, go to SKID.
  - !in_valid & out_ready: go to EMPTY.
  - Neither: hold.
- SKID:
  - in_ready = 0; any in_valid is ignored.
  - out_ready: main <= skid, go to FULL.
  - Otherwise hold both registers.
- Ordering: strict FIFO. No entry is dropped, duplicated or reordered except by flush or reset.
- Producer side must hold in_data stable while in_valid & !in_ready. The block holds out_data stable while out_valid & !out_ready.
- Data registers load only on the conditions above (enable-style). They are not required to clear on flush.

## Timing
- Reset, while asserted:
  - state = EMPTY, out_valid = 0, count = 0, out_data = 0.
  - in_ready = 1 in the cycle after reset is sampled; reset has priority over every other input.
- Reset mid-operation: buffered entries are lost. No handshake completes in the reset cycle, even if in_valid & in_ready or out_valid & out_ready are high.
- flush (when reset is low):
  - Next state = EMPTY, regardless of in_valid/out_ready.
  - An input offered in the flush cycle is discarded.
  - An out_valid & out_ready in the flush cycle counts as a completed transfer on the consumer side.
- Latency: an entry accepted at edge N appears with out_valid = 1 after edge N (visible in cycle N+1) when the block was EMPTY.
- Throughput: 1 entry/cycle in steady state with out_ready held high.
- Full boundary (SKID): in_ready falls in the cycle after the second accept. in_ready rises in the cycle after the first out transfer.
- Empty boundary: out_valid falls in the cycle after the last out transfer, unless a simultaneous accept refills main.
- Simultaneous in and out transfer in FULL: count stays 1 and out_data updates to the new entry.

## Test plan
- Reset, then idle: out_valid = 0, count = 0, out_data = 0, and in_ready = 1 after reset deasserts.
- Streaming: send 0x01..0x10 back-to-back with out_ready = 1. Expect 0x01..0x10 in order on out_data starting 1 cycle later, in_ready constantly 1, count = 1 throughout.
- Backpressure:
  - Hold out_ready = 0 and offer 0xA1, 0xA2, 0xA3. Expect 0xA1 and 0xA2 accepted, count = 2, in_ready = 0, and 0xA3 held by the producer.
  - Raise out_ready. Expect 0xA1, 0xA2, 0xA3 in order with no loss.
- Random valid/ready: drive random in_valid and out_ready for 10k cycles. A scoreboard checks order and no loss/duplication, out_data stability under stall, and count equal to accepted minus delivered.
- Flush in SKID with in_valid = 1 (0x55): next cycle count = 0, out_valid = 0, in_ready = 1, and 0x55 never appears on the output.
- Reset asserted in FULL together with in_valid and out_ready: no transfer completes, and all outputs take their reset values the next cycle.
